// File: rtl/pwm_seq_pkg.sv
// -----------------------------------------------------------------------------
// pwm_seq_pkg
// Shared types and helpers for the PWM sequencer:
//   - pwm_state_e : sequencer state, 2-bit encoding (IDLE=0, SOFT=1, RUN=2, FAULT=3)
//   - DEF_*       : default divider / timing constants used as parameter defaults
//   - clamp_div   : clamps a divider value into [lo, hi]
// -----------------------------------------------------------------------------
package pwm_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SOFT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } pwm_state_e;

    localparam int DEF_CNT_WIDTH     = 16;
    localparam int DEF_START_OFF_DIV = 100;
    localparam int DEF_MIN_OFF_DIV   = 4;
    localparam int DEF_MAX_OFF_DIV   = 1000;
    localparam int DEF_START_CYCLES  = 64;
    localparam int DEF_SLEW_STEP     = 8;

    // Divider values are handled as 32-bit unsigned here so the helper is
    // independent of the instantiating module's CNT_WIDTH.
    function automatic logic [31:0] clamp_div(
        input logic [31:0] val,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        logic [31:0] res;
        if (val < lo) begin
            res = lo;
        end else if (val > hi) begin
            res = hi;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_seq_ctl_period_det.sv
// -----------------------------------------------------------------------------
// pwm_period_det
// Detects the start of a PWM period as the rising edge of the monitored
// transmitter output.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-high reset
//   pwm_in   in  monitored PWM output
//   pwm_edge out high for the cycle in which pwm_in is high and its
//                registered copy is still low
// -----------------------------------------------------------------------------
module pwm_period_det (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic pwm_edge
);

    logic pwm_d;
    logic pwm_q;

    always_comb begin
        pwm_d = pwm_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_edge = pwm_in & ~pwm_q;

endmodule

// File: rtl/pwm_seq_ctl.sv
// -----------------------------------------------------------------------------
// pwm_seq_ctl
// Sequencer / configuration controller for the PSU PWM transmitter. Runs a
// soft start on the fixed start divider, then applies PID divider requests
// (clamped, optionally slew limited) on PWM period boundaries. A fault forces
// the transmitter back onto its fixed start divider.
//
// Build option: define PWM_SEQ_SLEW_EN to limit each per-period divider move to
// SLEW_STEP. Without it the divider jumps straight to the target in one step.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   enable       level, high requests operation
//   fault        level, external fault (OCP/OVP)
//   pwm_out      monitored transmitter output (period edge source)
//   req_valid    PID request valid
//   req_off_div  requested off divider
//   req_ready    request accepted on req_valid && req_ready (from state only)
//   off_div      divider driven to the transmitter (registered)
//   pwm_chg      one-cycle load strobe, off_div valid in the same cycle
//   act_ctl      high selects the transmitter's fixed start divider
//   state        current state (IDLE=0, SOFT=1, RUN=2, FAULT=3)
// -----------------------------------------------------------------------------
module pwm_seq_ctl
    import pwm_seq_pkg::*;
#(
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int START_OFF_DIV = DEF_START_OFF_DIV,
    parameter int MIN_OFF_DIV   = DEF_MIN_OFF_DIV,
    parameter int MAX_OFF_DIV   = DEF_MAX_OFF_DIV,
    parameter int START_CYCLES  = DEF_START_CYCLES,
    parameter int SLEW_STEP     = DEF_SLEW_STEP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 fault,
    input  logic                 pwm_out,
    input  logic                 req_valid,
    input  logic [CNT_WIDTH-1:0] req_off_div,
    output logic                 req_ready,
    output logic [CNT_WIDTH-1:0] off_div,
    output logic                 pwm_chg,
    output logic                 act_ctl,
    output logic [1:0]           state
);

    localparam int CYC_W = $clog2(START_CYCLES + 1);

`ifdef PWM_SEQ_SLEW_EN
    localparam int SLEW_LIMIT = SLEW_STEP;
`else
    // A limit no smaller than the whole divider range means every move
    // reaches the target in a single step.
    localparam int SLEW_LIMIT = (MAX_OFF_DIV > SLEW_STEP) ? MAX_OFF_DIV : SLEW_STEP;
`endif

    localparam logic [CNT_WIDTH-1:0]        START_DIV = CNT_WIDTH'(START_OFF_DIV);
    localparam logic [CNT_WIDTH-1:0]        LIMIT_U   = CNT_WIDTH'(SLEW_LIMIT);
    localparam logic signed [CNT_WIDTH:0]   LIMIT_S   = (CNT_WIDTH+1)'(SLEW_LIMIT);
    localparam logic [CYC_W-1:0]            CYC_END   = CYC_W'(START_CYCLES);

    pwm_state_e             state_q,   state_d;
    logic [CNT_WIDTH-1:0]   target_q,  target_d;
    logic [CNT_WIDTH-1:0]   off_div_q, off_div_d;
    logic                   pwm_chg_q, pwm_chg_d;
    logic                   act_ctl_q, act_ctl_d;
    logic [CYC_W-1:0]       cyc_cnt_q, cyc_cnt_d;

    logic                   pwm_edge;
    logic [CNT_WIDTH-1:0]   req_clamped;
    logic signed [CNT_WIDTH:0] diff;
    logic [CNT_WIDTH-1:0]   step_div;
    logic [CYC_W-1:0]       cyc_inc;

    pwm_period_det u_period_det (
        .clk      (clk),
        .rst      (rst),
        .pwm_in   (pwm_out),
        .pwm_edge (pwm_edge)
    );

    assign req_clamped = CNT_WIDTH'(clamp_div(32'(req_off_div),
                                              32'(MIN_OFF_DIV),
                                              32'(MAX_OFF_DIV)));

    // Signed one-bit-wider difference so moves in either direction never wrap.
    always_comb begin
        diff = $signed({1'b0, target_q}) - $signed({1'b0, off_div_q});
        if (diff > LIMIT_S) begin
            step_div = off_div_q + LIMIT_U;
        end else if (diff < -LIMIT_S) begin
            step_div = off_div_q - LIMIT_U;
        end else begin
            step_div = target_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        off_div_d = off_div_q;
        cyc_cnt_d = cyc_cnt_q;
        pwm_chg_d = 1'b0;
        cyc_inc   = cyc_cnt_q + 1'b1;

        if (fault) begin
            // Default pwm_chg_d=0 also suppresses any strobe due this cycle.
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_d   = ST_SOFT;
                        cyc_cnt_d = '0;
                    end
                end
                ST_FAULT: begin
                    if (!enable) begin
                        state_d   = ST_IDLE;
                        target_d  = START_DIV;
                        off_div_d = START_DIV;
                    end
                end
                default: begin
                    if (!enable) begin
                        // Entering IDLE overrides any request accepted now.
                        state_d   = ST_IDLE;
                        target_d  = START_DIV;
                        off_div_d = START_DIV;
                    end else begin
                        if (pwm_edge) begin
                            if (state_q == ST_SOFT) begin
                                cyc_cnt_d = cyc_inc;
                                if (cyc_inc == CYC_END) begin
                                    state_d   = ST_RUN;
                                    off_div_d = START_DIV;
                                    pwm_chg_d = 1'b1;
                                end
                            end else if (off_div_q != target_q) begin
                                // Steps toward the target held before any
                                // request accepted in this same cycle.
                                off_div_d = step_div;
                                pwm_chg_d = 1'b1;
                            end
                        end
                        if (req_valid) begin
                            target_d = req_clamped;
                        end
                    end
                end
            endcase
        end

        act_ctl_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            target_q  <= START_DIV;
            off_div_q <= START_DIV;
            pwm_chg_q <= 1'b0;
            act_ctl_q <= 1'b1;
            cyc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            off_div_q <= off_div_d;
            pwm_chg_q <= pwm_chg_d;
            act_ctl_q <= act_ctl_d;
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign req_ready = (state_q == ST_SOFT) || (state_q == ST_RUN);
    assign off_div   = off_div_q;
    assign pwm_chg   = pwm_chg_q;
    assign act_ctl   = act_ctl_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pwm_seq_ctl.sv
// -----------------------------------------------------------------------------
// tb_pwm_seq_ctl
// Directed stimulus for pwm_seq_ctl with a behavioural reference model and a
// per-cycle compare process, plus literal expectations on key scenarios.
// Honors PWM_SEQ_SLEW_EN in the same way as the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pwm_seq_ctl;

    localparam int START_DIV = 100;
    localparam int MIN_DIV   = 4;
    localparam int MAX_DIV   = 1000;
    localparam int START_CYC = 4;
    localparam int SLEW      = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        fault = 1'b0;
    logic        pwm_out = 1'b0;
    logic        req_valid = 1'b0;
    logic [15:0] req_off_div = 16'd0;
    logic        req_ready;
    logic [15:0] off_div;
    logic        pwm_chg;
    logic        act_ctl;
    logic [1:0]  state;

    pwm_seq_ctl #(
        .CNT_WIDTH     (16),
        .START_OFF_DIV (START_DIV),
        .MIN_OFF_DIV   (MIN_DIV),
        .MAX_OFF_DIV   (MAX_DIV),
        .START_CYCLES  (START_CYC),
        .SLEW_STEP     (SLEW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .fault       (fault),
        .pwm_out     (pwm_out),
        .req_valid   (req_valid),
        .req_off_div (req_off_div),
        .req_ready   (req_ready),
        .off_div     (off_div),
        .pwm_chg     (pwm_chg),
        .act_ctl     (act_ctl),
        .state       (state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // States as plain integers: 0 idle, 1 soft start, 2 run, 3 fault.
    int m_state  = 0;
    int m_target = START_DIV;
    int m_off    = START_DIV;
    int m_periods = 0;
    bit m_prev   = 1'b0;
    bit m_chg    = 1'b0;

    function automatic int clamp_int(input int v);
        if (v < MIN_DIV) return MIN_DIV;
        if (v > MAX_DIV) return MAX_DIV;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_target = START_DIV; m_off = START_DIV;
            m_periods = 0; m_prev = 1'b0; m_chg = 1'b0;
        end else begin
            bit rise;
            int gap;
            rise   = pwm_out && !m_prev;
            m_prev = pwm_out;
            m_chg  = 1'b0;
            if (fault) begin
                m_state = 3;
            end else if (m_state == 0) begin
                if (enable) begin m_state = 1; m_periods = 0; end
            end else if (!enable) begin
                // leaving soft/run/fault toward idle restores the start divider
                if (m_state != 3 || !enable) begin
                    m_state = 0; m_target = START_DIV; m_off = START_DIV;
                end
            end else if (m_state != 3) begin
                if (rise && m_state == 1) begin
                    m_periods = m_periods + 1;
                    if (m_periods == START_CYC) begin
                        m_state = 2; m_off = START_DIV; m_chg = 1'b1;
                    end
                end else if (rise && m_state == 2 && m_off != m_target) begin
                    gap = m_target - m_off;
`ifdef PWM_SEQ_SLEW_EN
                    if (gap > SLEW) gap = SLEW;
                    if (gap < -SLEW) gap = -SLEW;
`endif
                    m_off = m_off + gap;
                    m_chg = 1'b1;
                end
                if (req_valid) m_target = clamp_int(int'(req_off_div));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("state",     32'(state),     32'(m_state));
            check("off_div",   32'(off_div),   32'(m_off));
            check("pwm_chg",   32'(pwm_chg),   32'(m_chg));
            check("act_ctl",   32'(act_ctl),   32'(m_state != 2));
            check("req_ready", 32'(req_ready), 32'(m_state == 1 || m_state == 2));
            check("off_div_bounds", 32'(state != 2 || (off_div >= MIN_DIV && off_div <= MAX_DIV)), 32'd1);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic        s_chg;
    logic        s_act;
    logic [1:0]  s_state;
    logic [15:0] s_div;

    // One PWM period (2 cycles high, 2 low); samples outputs right after the rise.
    task automatic period();
        pwm_out = 1'b1;
        @(negedge clk);
        s_chg = pwm_chg; s_act = act_ctl; s_state = state; s_div = off_div;
        @(negedge clk);
        pwm_out = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("period: state=%0d off_div=%0d pwm_chg=%0d act_ctl=%0d", s_state, s_div, s_chg, s_act);
    endtask

    task automatic run_periods(input int n);
        for (int i = 0; i < n; i++) period();
    endtask

    task automatic send_req(input int v);
        req_valid = 1'b1;
        req_off_div = 16'(v);
        @(negedge clk);
        req_valid = 1'b0;
        $display("request: req_off_div=%0d", v);
    endtask

`ifdef PWM_SEQ_SLEW_EN
    int exp_ramp[4] = '{108, 116, 124, 130};
    bit exp_rchg[4] = '{1, 1, 1, 1};
    localparam int EXP_SIM  = 108;
    localparam int EXP_300  = 108;
`else
    int exp_ramp[4] = '{130, 130, 130, 130};
    bit exp_rchg[4] = '{1, 0, 0, 0};
    localparam int EXP_SIM  = 120;
    localparam int EXP_300  = 300;
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        // reset state
        check("rst_state", 32'(state), 32'd0);
        check("rst_off_div", 32'(off_div), 32'd100);
        check("rst_pwm_chg", 32'(pwm_chg), 32'd0);
        check("rst_act_ctl", 32'(act_ctl), 32'd1);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        $display("reset: state=%0d off_div=%0d", state, off_div);

        // soft start
        rst = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("soft_state", 32'(state), 32'd1);
        check("soft_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            period();
            check("soft_hold_state", 32'(s_state), 32'd1);
            check("soft_hold_chg", 32'(s_chg), 32'd0);
        end
        period();
        check("run_entry_state", 32'(s_state), 32'd2);
        check("run_entry_act", 32'(s_act), 32'd0);
        check("run_entry_chg", 32'(s_chg), 32'd1);
        check("run_entry_div", 32'(s_div), 32'd100);

        // slew toward 130
        send_req(130);
        for (int i = 0; i < 4; i++) begin
            period();
            check("ramp_div", 32'(s_div), 32'(exp_ramp[i]));
            check("ramp_chg", 32'(s_chg), 32'(exp_rchg[i]));
        end
        period();
        check("ramp_done_chg", 32'(s_chg), 32'd0);

        // back to 100, then request coinciding with an edge
        send_req(100);
        run_periods(6);
        check("back_div", 32'(off_div), 32'd100);
        pwm_out = 1'b1; req_valid = 1'b1; req_off_div = 16'd120;
        @(negedge clk);
        req_valid = 1'b0;
        check("sim_edge_chg", 32'(pwm_chg), 32'd0);
        check("sim_edge_div", 32'(off_div), 32'd100);
        @(negedge clk);
        pwm_out = 1'b0;
        repeat (2) @(negedge clk);
        period();
        check("sim_next_div", 32'(s_div), 32'(EXP_SIM));
        check("sim_next_chg", 32'(s_chg), 32'd1);
        run_periods(3);

        // clamping
        send_req(2);
        run_periods(20);
        check("clamp_lo_div", 32'(off_div), 32'd4);
        period();
        check("clamp_lo_chg", 32'(s_chg), 32'd0);
        send_req(5000);
        run_periods(130);
        check("clamp_hi_div", 32'(off_div), 32'd1000);
        period();
        check("clamp_hi_chg", 32'(s_chg), 32'd0);

        // fault mid-ramp
        send_req(500);
        run_periods(2);
        pwm_out = 1'b1; fault = 1'b1;
        @(negedge clk);
        check("fault_state", 32'(state), 32'd3);
        check("fault_act", 32'(act_ctl), 32'd1);
        check("fault_chg", 32'(pwm_chg), 32'd0);
        check("fault_ready", 32'(req_ready), 32'd0);
        pwm_out = 1'b0; fault = 1'b0;
        repeat (3) @(negedge clk);
        check("fault_hold", 32'(state), 32'd3);
        enable = 1'b0;
        @(negedge clk);
        check("fault_exit_state", 32'(state), 32'd0);
        check("fault_exit_div", 32'(off_div), 32'd100);
        $display("fault: exited to state=%0d", state);

        // request discarded when enable falls in the same cycle
        enable = 1'b1;
        @(negedge clk);
        run_periods(4);
        req_valid = 1'b1; req_off_div = 16'd300; enable = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("drop_state", 32'(state), 32'd0);
        check("drop_div", 32'(off_div), 32'd100);
        enable = 1'b1;
        @(negedge clk);
        run_periods(4);
        check("rerun_div", 32'(s_div), 32'd100);
        period();
        check("rerun_nochg", 32'(s_chg), 32'd0);

        // reset mid-operation
        send_req(200);
        period();
        #2 rst = 1'b1;
        #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_div", 32'(off_div), 32'd100);
        check("midrst_chg", 32'(pwm_chg), 32'd0);
        check("midrst_act", 32'(act_ctl), 32'd1);
        $display("mid-op reset: state=%0d off_div=%0d", state, off_div);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_periods(4);
        send_req(300);
        period();
        check("req300_div", 32'(s_div), 32'(EXP_300));
        check("req300_chg", 32'(s_chg), 32'd1);
        period();

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_seq_ctl.md
# pwm_seq_ctl

Sequencer and configuration controller for the PWM transmitter in the PSU datapath. It owns the transmitter's `off_div`, `pwm_chg` and `act_ctl` inputs and performs soft start, clamping and slew limiting. It accepts off-divider requests from the PID loop over a valid/ready handshake and applies each update only on a PWM period boundary. Fault handling is included: a fault forces the transmitter back to the fixed start divider.

## Interface

Parameters:
- CNT_WIDTH, 16, width of all divider values
- START_OFF_DIV, 100, divider used during soft start and after reset
- MIN_OFF_DIV, 4, lower clamp for requested divider
- MAX_OFF_DIV, 1000, upper clamp for requested divider
- START_CYCLES, 64, PWM periods spent in soft start
- SLEW_STEP, 8, maximum divider change per PWM period

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  level; high requests operation
- fault  in  1  level; external fault (OCP/OVP)
- pwm_out  in  1  monitored transmitter output
- req_valid  in  1  PID request valid
- req_off_div  in  CNT_WIDTH  requested off divider
- req_ready  out  1  request accepted when `req_valid && req_ready`
- off_div  out  CNT_WIDTH  divider driven to the transmitter
- pwm_chg  out  1  one-cycle load strobe to the transmitter
- act_ctl  out  1  high selects the transmitter's fixed start divider
- state  out  2  current state (IDLE=0, SOFT=1, RUN=2, FAULT=3)

## Operation

- **Period edge:** `pwm_q` is a registered copy of `pwm_out`. `edge = pwm_out & ~pwm_q`.
- **IDLE:**
  - `act_ctl=1`, `req_ready=0`.
  - On entry: `target := START_OFF_DIV` and `off_div := START_OFF_DIV`.
  - When `enable=1`: go to SOFT and clear the period counter.
- **SOFT:**
  - `act_ctl=1`, `req_ready=1`.
  - The period counter increments on each `edge`. Counter width is `$clog2(START_CYCLES+1)`.
  - On the edge that makes count == START_CYCLES: go to RUN, `act_ctl:=0`, pulse `pwm_chg` with `off_div=START_OFF_DIV`.
- **RUN:**
  - `act_ctl=0`, `req_ready=1`.
  - On each `edge` where `off_div != target`: `off_div` moves toward `target` by `min(|target-off_div|, SLEW_STEP)`, and `pwm_chg` pulses.
  - No pulse is issued when `off_div == target`.
- **Request accept:** `target := clamp(req_off_div, MIN_OFF_DIV, MAX_OFF_DIV)`. The last accepted request wins.
- **FAULT:**
  - Entered from any state the cycle after `fault=1`. `act_ctl=1`, `req_ready=0`.
  - Leaves to IDLE only when `fault=0` and `enable=0`.
- **enable low** in SOFT or RUN: go to IDLE next cycle.
- **Priority:** fault > enable low > edge processing > request accept.
- **Arithmetic:** the difference is computed in CNT_WIDTH+1 bits, signed. `off_div` never leaves [MIN_OFF_DIV, MAX_OFF_DIV] after RUN entry. No wrap.

## Timing

- **Reset values:** `off_div=START_OFF_DIV`, `pwm_chg=0`, `act_ctl=1`, `req_ready=0`, `state=IDLE`, `target=START_OFF_DIV`, `pwm_q=0`.
- `req_ready` is combinational from `state`. All other outputs are registered.
- **Edge latency:** `pwm_out` is high and `pwm_q` is low at cycle N; `off_div` and `pwm_chg` are updated at N+1.
- `pwm_chg` is high for exactly one cycle, with `off_div` valid in the same cycle.
- **Request and edge in the same cycle:** the edge steps toward the old target. The new target applies from the next edge.
- **Fault:** `fault` sampled high at cycle N gives `state=FAULT` and `act_ctl=1` at N+1. Any `pwm_chg` scheduled for N+1 is suppressed.
- **Request with enable falling:** a request accepted in the same cycle as `enable` falls is discarded on IDLE entry.
- **Reset mid-operation:** all registers return to reset values immediately. No `pwm_chg` is issued.

## Configuration

- **Macro:** `PWM_SEQ_SLEW_EN`.
- **Defined:** slew limiting by SLEW_STEP as described above.
- **Undefined:** on each `edge` in RUN with `off_div != target`, `off_div := target` in a single step with one `pwm_chg` pulse. The SLEW_STEP parameter is retained but unused.

## Structure

- **Package `pwm_seq_pkg`:**
  - state enum (IDLE, SOFT, RUN, FAULT) with 2-bit encoding
  - `clamp_div` function
  - default divider constants
- **Sub-module `pwm_period_det`:** the `pwm_out` register plus the `edge` output. It is reused by other PWM monitors.

## Test plan

- **Soft start:** reset with START_CYCLES=4, then `enable=1`. Expect SOFT; on the 4th `pwm_out` rise, RUN with `act_ctl=0` next cycle and a single `pwm_chg` with `off_div=100`.
- **Slew:** in RUN, request 130. Expect `off_div` 108, 116, 124, 130 on four consecutive period edges, then no further `pwm_chg`.
- **Clamp:** request 2 and expect `target=4`. Request 5000 and expect `target=1000`. `off_div` never goes outside these bounds.
- **Fault:**
  - Assert `fault` mid-ramp: expect `state=FAULT` and `act_ctl=1` next cycle, with no `pwm_chg`.
  - Deassert `fault` with `enable=1`: expect it to stay in FAULT.
  - Drop `enable`: expect IDLE.
- **Simultaneous request and edge:** at `off_div=100`, request 120 in the same cycle as an edge. Expect no change at that edge and 108 at the next edge.
- **Macro off:** rebuild without `PWM_SEQ_SLEW_EN`. Request 300 from 100 and expect `off_div=300` after one edge, with one `pwm_chg`.
